timing: RTL and testbench
=========================

TIMING -- requirements
Module: timing

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and reset.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-003 Port `reset`: input, 1 bit, asynchronous active-low reset; 0 clears all state immediately.
REQ-004 Port `ro_trig_start`: input, 1 bit, start request; only its rising edge acts.
REQ-005 Port `ro_trig_halt`: input, 1 bit, halt request; only its rising edge acts.
REQ-006 Port `ro_mode`: input, 1 bit; 0 = one-shot, 1 = periodic (auto-reload).
REQ-007 Port `ro_termcount`: input, 32 bits, terminal count value.
REQ-008 Port `rf_status`: output, 1 bit; 1 = timer running.
REQ-009 Port `rf_currcount`: output, 32 bits, current count value, registered.
REQ-010 Port `rf_int`: output, 1 bit, one-clock terminal-count interrupt pulse, registered.

Function
REQ-011 Edge detection SHALL use one previous-value register per trigger, reset to 0; an edge is prev=0 and current=1.
- An input already high when reset releases SHALL produce an edge on the first clock.
REQ-012 On a start edge, the block SHALL, at the same clock:
- latch ro_termcount and ro_mode into internal registers;
- set rf_currcount=0 and rf_status=1.
REQ-013 Changes to ro_termcount or ro_mode while running SHALL have no effect until the next start edge.
REQ-014 While running, with currcount != latched termcount, currcount SHALL increment by 1 per clock.
REQ-015 While running, with currcount == latched termcount, the next clock SHALL assert rf_int for exactly one cycle, and:
- periodic: currcount becomes 0 and rf_status stays 1 (period = termcount+1 clocks);
- one-shot: currcount holds termcount and rf_status becomes 0.
REQ-016 Latched termcount=0 SHALL be legal:
- periodic: rf_int high every clock from the second clock after start;
- one-shot: a single pulse.
REQ-017 A halt edge SHALL clear rf_status at the next clock, hold rf_currcount, and suppress rf_int that cycle.
REQ-018 A halt edge while idle SHALL have no effect.
REQ-019 Start and halt edges on the same clock: halt SHALL win; the timer ends idle with count held.
REQ-020 A start edge while running SHALL restart from 0 and relatch termcount and mode.
REQ-021 While idle, rf_currcount SHALL hold its value and rf_int SHALL stay 0.
REQ-022 The counter SHALL be 32-bit unsigned.
- Terminal detection is by equality, so wrap past 0xFFFFFFFF never occurs.
- termcount=0xFFFFFFFF SHALL give a period of 2^32 clocks.

Reset
REQ-023 While reset=0: rf_status=0, rf_currcount=0, rf_int=0, latched termcount=0, latched mode=0, and both edge registers=0.
REQ-024 Reset asserted mid-count SHALL abort the run immediately.
REQ-025 After reset releases, the timer SHALL remain idle until a new start edge.

Verification
REQ-026 Periodic: ro_mode=1, ro_termcount=10, start raised and held → count 0..10 repeating; rf_int pulses every 11 clocks, first on the clock after count=10; rf_status stays 1.
REQ-027 One-shot: ro_mode=0, termcount=5, start pulse → count 0..5, single rf_int pulse, rf_status=0, count holds 5; start held high does not retrigger.
REQ-028 Halt: periodic, termcount=10, halt edge at count=4 → rf_status=0, count frozen at 4 or 5 per REQ-017 timing, no rf_int; a new start restarts from 0.
REQ-029 Simultaneous start and halt edges while idle → rf_status stays 0.
REQ-030 Reset mid-run: assert reset at count=7 → all outputs 0 immediately; after release, the timer stays idle until a fresh start edge.
REQ-031 Termcount change mid-run: change ro_termcount from 10 to 3 at count=2 → terminal stays at 10 until restart.

Source files
------------

// File: rtl/timing.sv
// Start/halt controlled 32-bit timer with one-shot and periodic (auto-reload) modes.
// Triggers act on rising edges only; all outputs come straight from registers.
module timing (
    input  logic        clk,
    input  logic        reset,
    input  logic        ro_trig_start,
    input  logic        ro_trig_halt,
    input  logic        ro_mode,
    input  logic [31:0] ro_termcount,
    output logic        rf_status,
    output logic [31:0] rf_currcount,
    output logic        rf_int
);

    logic        start_prev_r;
    logic        halt_prev_r;
    logic        mode_r;
    logic [31:0] term_r;
    logic [31:0] count_r;
    logic        status_r;
    logic        int_r;

    logic        start_edge_s;
    logic        halt_edge_s;
    logic        terminal_s;
    logic        mode_next_s;
    logic [31:0] term_next_s;
    logic [31:0] count_next_s;
    logic        status_next_s;
    logic        int_next_s;

    // Edge detection and next-state selection; halt outranks start.
    always_comb begin
        start_edge_s  = ro_trig_start & ~start_prev_r;
        halt_edge_s   = ro_trig_halt & ~halt_prev_r;
        terminal_s    = (count_r == term_r);
        mode_next_s   = mode_r;
        term_next_s   = term_r;
        count_next_s  = count_r;
        status_next_s = status_r;
        int_next_s    = 1'b0;

        if (halt_edge_s) begin
            status_next_s = 1'b0;
        end else if (start_edge_s) begin
            mode_next_s   = ro_mode;
            term_next_s   = ro_termcount;
            count_next_s  = 32'd0;
            status_next_s = 1'b1;
        end else if (status_r) begin
            if (terminal_s) begin
                int_next_s = 1'b1;
                if (mode_r) begin
                    count_next_s = 32'd0;
                end else begin
                    status_next_s = 1'b0;
                end
            end else begin
                count_next_s = count_r + 32'd1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_prev_r <= 1'b0;
            halt_prev_r  <= 1'b0;
            mode_r       <= 1'b0;
            term_r       <= 32'd0;
            count_r      <= 32'd0;
            status_r     <= 1'b0;
            int_r        <= 1'b0;
        end else begin
            start_prev_r <= ro_trig_start;
            halt_prev_r  <= ro_trig_halt;
            mode_r       <= mode_next_s;
            term_r       <= term_next_s;
            count_r      <= count_next_s;
            status_r     <= status_next_s;
            int_r        <= int_next_s;
        end
    end

    assign rf_status    = status_r;
    assign rf_currcount = count_r;
    assign rf_int       = int_r;

endmodule

// File: tb/tb_timing.sv
// Directed self-checking bench for the timing block; inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_timing;

    logic        clk;
    logic        reset;
    logic        ro_trig_start;
    logic        ro_trig_halt;
    logic        ro_mode;
    logic [31:0] ro_termcount;
    logic        rf_status;
    logic [31:0] rf_currcount;
    logic        rf_int;

    int total;
    int bad;

    timing dut (
        .clk          (clk),
        .reset        (reset),
        .ro_trig_start(ro_trig_start),
        .ro_trig_halt (ro_trig_halt),
        .ro_mode      (ro_mode),
        .ro_termcount (ro_termcount),
        .rf_status    (rf_status),
        .rf_currcount (rf_currcount),
        .rf_int       (rf_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [31:0] cnt, input logic st, input logic it);
        check({tag, ".count"}, rf_currcount, cnt);
        check({tag, ".status"}, {31'd0, rf_status}, {31'd0, st});
        check({tag, ".int"}, {31'd0, rf_int}, {31'd0, it});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        ro_trig_start = 1'b0;
        ro_trig_halt  = 1'b0;
        ro_mode       = 1'b0;
        ro_termcount  = 32'd0;
        #12;
        check3("reset", 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        check3("idle_after_reset", 32'd0, 1'b0, 1'b0);

        // Periodic, termcount 10; termcount/mode changed at count 2 must be ignored
        ro_mode = 1'b1;
        ro_termcount = 32'd10;
        ro_trig_start = 1'b1;
        tick();
        check3("per_start", 32'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check3("per_count", k, 1'b1, 1'b0);
            if (k == 2) begin
                ro_termcount = 32'd3;
                ro_mode = 1'b0;
            end
        end
        tick();
        check3("per_wrap", 32'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check3("per_count2", k, 1'b1, 1'b0);
        end

        // Halt at count 4
        ro_trig_halt = 1'b1;
        tick();
        check3("halt", 32'd4, 1'b0, 1'b0);
        tick();
        check3("halt_hold", 32'd4, 1'b0, 1'b0);

        // One-shot, termcount 5, start held high afterwards
        ro_trig_start = 1'b0;
        ro_trig_halt  = 1'b0;
        tick();
        ro_mode = 1'b0;
        ro_termcount = 32'd5;
        ro_trig_start = 1'b1;
        tick();
        check3("os_start", 32'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check3("os_count", k, 1'b1, 1'b0);
        end
        tick();
        check3("os_term", 32'd5, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check3("os_hold", 32'd5, 1'b0, 1'b0);
        end

        // Halt edge while idle
        ro_trig_halt = 1'b1;
        tick();
        check3("halt_idle", 32'd5, 1'b0, 1'b0);
        ro_trig_halt = 1'b0;
        ro_trig_start = 1'b0;
        tick();

        // Simultaneous start and halt edges while idle
        ro_mode = 1'b1;
        ro_termcount = 32'd10;
        ro_trig_start = 1'b1;
        ro_trig_halt  = 1'b1;
        tick();
        check3("simul", 32'd5, 1'b0, 1'b0);
        tick();
        check3("simul_after", 32'd5, 1'b0, 1'b0);
        ro_trig_start = 1'b0;
        ro_trig_halt  = 1'b0;
        tick();

        // Periodic, termcount 0
        ro_mode = 1'b1;
        ro_termcount = 32'd0;
        ro_trig_start = 1'b1;
        tick();
        check3("t0_start", 32'd0, 1'b1, 1'b0);
        tick();
        check3("t0_int1", 32'd0, 1'b1, 1'b1);
        tick();
        check3("t0_int2", 32'd0, 1'b1, 1'b1);

        // Restart while running, then reset at count 7
        ro_termcount = 32'd10;
        ro_trig_start = 1'b0;
        tick();
        check3("t0_int3", 32'd0, 1'b1, 1'b1);
        ro_trig_start = 1'b1;
        tick();
        check3("restart", 32'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) tick();
        check3("pre_reset", 32'd7, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check3("async_reset", 32'd0, 1'b0, 1'b0);
        ro_trig_start = 1'b0;
        #2;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check3("post_reset_idle", 32'd0, 1'b0, 1'b0);
        end

        // Start already high when reset releases acts on the first clock
        reset = 1'b0;
        #1;
        ro_trig_start = 1'b1;
        #1;
        reset = 1'b1;
        tick();
        check3("start_at_release", 32'd0, 1'b1, 1'b0);
        tick();
        check3("count_after_release", 32'd1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
